// File: rtl/alu_sched.sv
// Round-robin front end for the power-gated ALU: grants one of two requesters, drives start/operands, owns power and isolation.
// Response 3 cycles after accept for single-cycle ops; requesters stall on reqX_ready, and responses are not backpressured.
module alu_sched #(
  parameter int PWR_UP_CYC   = 4,
  parameter int IDLE_TIMEOUT = 16,
  parameter int ISO_LEAD     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        force_off,
  input  logic        req0_valid,
  input  logic [3:0]  req0_opcode,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [3:0]  req1_opcode,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        req1_ready,
  output logic        alu_pwr_en,
  output logic        iso_en,
  output logic        alu_start,
  output logic [3:0]  alu_opcode,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic        alu_busy,
  input  logic [15:0] alu_result,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [15:0] resp_data,
  output logic        resp_err,
  output logic [2:0]  ctrl_state
);

  localparam int IW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_PWR_UP = 3'd1,
    ST_READY  = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_ISO    = 3'd5
  } state_t;

  state_t        state;
  logic [7:0]    phase_cnt;
  logic [IW-1:0] idle_cnt;
  logic          rr_last;
  logic          cur_id;

  logic          any_valid;
  logic          win_id;
  logic          grant_ok;
  logic          accept;
  logic [3:0]    acc_opcode;
  logic [15:0]   acc_a;
  logic [15:0]   acc_b;
  logic          op_bad;

  // When both requesters are valid, the one that did not win last time gets the ALU.
  assign any_valid  = req0_valid | req1_valid;
  assign win_id     = (req0_valid & req1_valid) ? ~rr_last : req1_valid;
  assign grant_ok   = (state == ST_READY) & ~force_off;
  assign req0_ready = grant_ok & req0_valid & ~win_id;
  assign req1_ready = grant_ok & req1_valid & win_id;
  assign accept     = req0_ready | req1_ready;
  assign acc_opcode = win_id ? req1_opcode : req0_opcode;
  assign acc_a      = win_id ? req1_a : req0_a;
  assign acc_b      = win_id ? req1_b : req0_b;
  assign op_bad     = acc_opcode > 4'b1001;
  assign ctrl_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_OFF;
      phase_cnt  <= '0;
      idle_cnt   <= '0;
      rr_last    <= 1'b1;
      cur_id     <= 1'b0;
      alu_pwr_en <= 1'b0;
      iso_en     <= 1'b1;
      alu_start  <= 1'b0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      alu_start  <= 1'b0;
      resp_valid <= 1'b0;
      case (state)
        ST_OFF: begin
          if (any_valid && !force_off) begin
            state      <= ST_PWR_UP;
            alu_pwr_en <= 1'b1;
            iso_en     <= 1'b1;
            phase_cnt  <= '0;
          end
        end
        ST_PWR_UP: begin
          if (force_off) begin
            state     <= ST_ISO;
            phase_cnt <= '0;
          end else if (phase_cnt == 8'(PWR_UP_CYC - 1)) begin
            state    <= ST_READY;
            iso_en   <= 1'b0;
            idle_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end
        ST_READY: begin
          if (force_off) begin
            state     <= ST_ISO;
            iso_en    <= 1'b1;
            phase_cnt <= '0;
            idle_cnt  <= '0;
          end else if (accept) begin
            alu_opcode <= acc_opcode;
            alu_a      <= acc_a;
            alu_b      <= acc_b;
            cur_id     <= win_id;
            rr_last    <= win_id;
            idle_cnt   <= '0;
            // Unsupported opcodes never reach the ALU; answer them directly.
            if (op_bad) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= '0;
              resp_id    <= win_id;
            end else begin
              state     <= ST_ISSUE;
              alu_start <= 1'b1;
            end
          end else if (idle_cnt == IW'(IDLE_TIMEOUT - 1)) begin
            state     <= ST_ISO;
            iso_en    <= 1'b1;
            phase_cnt <= '0;
            idle_cnt  <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!alu_busy) begin
            state      <= ST_READY;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_data  <= alu_result;
            resp_id    <= cur_id;
            idle_cnt   <= '0;
          end
        end
        ST_ISO: begin
          // A fresh request while still powered cancels the shutdown.
          if (any_valid && !force_off) begin
            state    <= ST_READY;
            iso_en   <= 1'b0;
            idle_cnt <= '0;
          end else if (phase_cnt == 8'(ISO_LEAD - 1)) begin
            state      <= ST_OFF;
            alu_pwr_en <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end
        default: begin
          state      <= ST_OFF;
          alu_pwr_en <= 1'b0;
          iso_en     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a small multi-cycle ALU model driving alu_busy/alu_result.
module tb_alu_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        force_off;
  logic        req0_valid, req1_valid;
  logic [3:0]  req0_opcode, req1_opcode;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        alu_pwr_en, iso_en, alu_start;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_a, alu_b;
  logic        alu_busy;
  logic [15:0] alu_result;
  logic        resp_valid, resp_id, resp_err;
  logic [15:0] resp_data;
  logic [2:0]  ctrl_state;

  always #5 clk = ~clk;

  alu_sched dut (
    .clk(clk), .rst(rst), .force_off(force_off),
    .req0_valid(req0_valid), .req0_opcode(req0_opcode), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_opcode(req1_opcode), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .alu_pwr_en(alu_pwr_en), .iso_en(iso_en), .alu_start(alu_start),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_busy(alu_busy), .alu_result(alu_result),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
    .ctrl_state(ctrl_state)
  );

  // ALU model: busy for 5 cycles after a MUL start, 9 after DIV, none otherwise.
  int unsigned busy_cnt;
  logic [31:0] prod;
  always @(posedge clk or posedge rst) begin
    if (rst) busy_cnt <= 0;
    else if (alu_start) busy_cnt <= (alu_opcode == 4'd8) ? 5 : (alu_opcode == 4'd9) ? 9 : 0;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign alu_busy = (busy_cnt != 0);

  always_comb begin
    alu_result = 16'h0000;
    prod = 32'(alu_a) * 32'(alu_b);
    case (alu_opcode)
      4'd0: alu_result = alu_a + alu_b;
      4'd1: alu_result = alu_a - alu_b;
      4'd2: alu_result = alu_a & alu_b;
      4'd3: alu_result = alu_a | alu_b;
      4'd4: alu_result = alu_a ^ alu_b;
      4'd8: alu_result = prod[15:0];
      4'd9: alu_result = (alu_b == 16'h0000) ? 16'h0000 : alu_a / alu_b;
      default: alu_result = 16'h0000;
    endcase
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    logic        id;
    logic        err;
    int          cyc;
  } rsp_t;

  rsp_t        rq[$];
  int          cyc = 0;
  int          acc_cyc[2];
  bit          drop0, drop1;
  int          n_start = 0;
  int          idle_run = 0;
  int          unstable = 0;
  logic [15:0] hold_a, hold_b;

  // Sample the current cycle, then advance one clock and retire accepted requests.
  task automatic tick();
    rsp_t r;
    #1;
    if (alu_start) n_start++;
    if (resp_valid) begin
      r.data = resp_data; r.id = resp_id; r.err = resp_err; r.cyc = cyc;
      rq.push_back(r);
    end
    if ((ctrl_state == 3'd3 || ctrl_state == 3'd4) && (alu_a !== hold_a || alu_b !== hold_b)) unstable++;
    if (req0_valid && req0_ready) begin drop0 = 1; acc_cyc[0] = cyc; hold_a = req0_a; hold_b = req0_b; end
    if (req1_valid && req1_ready) begin drop1 = 1; acc_cyc[1] = cyc; hold_a = req1_a; hold_b = req1_b; end
    if (ctrl_state == 3'd2) idle_run = (req0_valid || req1_valid) ? 0 : idle_run + 1;
    else if (ctrl_state != 3'd5) idle_run = 0;
    @(posedge clk); #1;
    cyc++;
    if (drop0) begin req0_valid = 1'b0; drop0 = 0; end
    if (drop1) begin req1_valid = 1'b0; drop1 = 0; end
  endtask

  task automatic post(input int who, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    if (who == 0) begin req0_valid = 1'b1; req0_opcode = op; req0_a = a; req0_b = b; acc_cyc[0] = -1; end
    else          begin req1_valid = 1'b1; req1_opcode = op; req1_a = a; req1_b = b; acc_cyc[1] = -1; end
  endtask

  task automatic wait_resp(input int n, input int budget);
    int k = 0;
    while (rq.size() < n && k < budget) begin tick(); k++; end
    if (rq.size() < n) check("resp_timeout", rq.size(), n);
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget);
    int k = 0;
    while (ctrl_state != st && k < budget) begin tick(); k++; end
    if (ctrl_state != st) check("state_timeout", ctrl_state, st);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pu, pu_bad, k;
    rst = 1'b1; force_off = 1'b0;
    req0_valid = 0; req0_opcode = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_opcode = 0; req1_a = 0; req1_b = 0;
    acc_cyc[0] = -1; acc_cyc[1] = -1; drop0 = 0; drop1 = 0;
    hold_a = 0; hold_b = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", ctrl_state, 3'd0);
    check("rst_pwr", alu_pwr_en, 1'b0);
    check("rst_iso", iso_en, 1'b1);
    check("rst_start", alu_start, 1'b0);
    check("rst_ready0", req0_ready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_alu_a", alu_a, 16'h0000);
    rst = 1'b0;
    @(posedge clk); #1;

    // Power-up then ADD
    n_start = 0;
    post(0, 4'd0, 16'h0003, 16'h0004);
    pu = 0; pu_bad = 0; k = 0;
    while (acc_cyc[0] < 0 && k < 30) begin
      if (ctrl_state == 3'd1) begin pu++; if (!(alu_pwr_en && iso_en)) pu_bad++; end
      tick(); k++;
    end
    check("pwrup_cycles", pu, 4);
    check("pwrup_rails_bad", pu_bad, 0);
    wait_resp(1, 30);
    check("add_data", rq[0].data, 16'h0007);
    check("add_id", rq[0].id, 1'b0);
    check("add_err", rq[0].err, 1'b0);
    check("add_latency", rq[0].cyc - acc_cyc[0], 3);
    check("add_start_pulses", n_start, 1);
    check("ready_iso", iso_en, 1'b0);

    // MUL from requester 1
    rq.delete(); unstable = 0;
    post(1, 4'd8, 16'h0012, 16'h0003);
    wait_resp(1, 40);
    check("mul_data", rq[0].data, 16'h0036);
    check("mul_id", rq[0].id, 1'b1);
    check("mul_latency", rq[0].cyc - acc_cyc[1], 8);
    check("mul_operands_unstable", unstable, 0);

    // Both valid, last winner was 1 -> requester 0 first
    rq.delete();
    post(0, 4'd1, 16'h0010, 16'h0001);
    post(1, 4'd4, 16'h00FF, 16'h0F0F);
    wait_resp(2, 40);
    check("pair1_first_id", rq[0].id, 1'b0);
    check("pair1_first_data", rq[0].data, 16'h000F);
    check("pair1_second_id", rq[1].id, 1'b1);
    check("pair1_second_data", rq[1].data, 16'h0FF0);
    check("pair1_b2b_accept", acc_cyc[1] - rq[0].cyc, 0);

    // DIV by zero from requester 0
    rq.delete(); unstable = 0;
    post(0, 4'd9, 16'h0064, 16'h0000);
    wait_resp(1, 40);
    check("div0_data", rq[0].data, 16'h0000);
    check("div0_err", rq[0].err, 1'b0);
    check("div0_latency", rq[0].cyc - acc_cyc[0], 12);
    check("div0_operands_unstable", unstable, 0);

    // Both valid again, last winner was 0 -> requester 1 first
    rq.delete();
    post(0, 4'd1, 16'h0010, 16'h0001);
    post(1, 4'd4, 16'h00FF, 16'h0F0F);
    wait_resp(2, 40);
    check("pair2_first_id", rq[0].id, 1'b1);
    check("pair2_first_data", rq[0].data, 16'h0FF0);
    check("pair2_second_id", rq[1].id, 1'b0);
    check("pair2_second_data", rq[1].data, 16'h000F);

    // Illegal opcode answered directly
    rq.delete(); n_start = 0;
    post(0, 4'hC, 16'h1234, 16'h5678);
    wait_resp(1, 10);
    check("bad_op_err", rq[0].err, 1'b1);
    check("bad_op_data", rq[0].data, 16'h0000);
    check("bad_op_latency", rq[0].cyc - acc_cyc[0], 1);
    repeat (3) tick();
    check("bad_op_no_start", n_start, 0);
    check("bad_op_state", ctrl_state, 3'd2);

    // Idle timeout -> ISO -> OFF
    wait_state(3'd5, 40);
    check("idle_run_len", idle_run, 16);
    check("iso_entry_iso", iso_en, 1'b1);
    check("iso_entry_pwr", alu_pwr_en, 1'b1);
    tick();
    check("iso_hold_pwr", alu_pwr_en, 1'b1);
    tick();
    check("off_state", ctrl_state, 3'd0);
    check("off_pwr", alu_pwr_en, 1'b0);

    // Wake, idle out again, abort in the first ISO cycle
    rq.delete();
    post(0, 4'd2, 16'h00F0, 16'h0FF0);
    wait_resp(1, 40);
    check("and_data", rq[0].data, 16'h00F0);
    rq.delete();
    wait_state(3'd5, 40);
    post(1, 4'd3, 16'h1200, 16'h0034);
    tick();
    check("abort_state", ctrl_state, 3'd2);
    check("abort_iso", iso_en, 1'b0);
    wait_resp(1, 20);
    check("abort_data", rq[0].data, 16'h1234);
    check("abort_id", rq[0].id, 1'b1);

    // force_off blocks accepts and holds the ALU off
    rq.delete();
    force_off = 1'b1;
    post(0, 4'd0, 16'h0001, 16'h0001);
    #1;
    check("force_off_ready", req0_ready, 1'b0);
    tick();
    check("force_off_iso_state", ctrl_state, 3'd5);
    repeat (5) tick();
    check("force_off_held_off", ctrl_state, 3'd0);
    check("force_off_no_resp", rq.size(), 0);
    force_off = 1'b0;
    wait_resp(1, 30);
    check("force_off_release_data", rq[0].data, 16'h0002);

    // Reset in the middle of a DIV
    rq.delete();
    post(0, 4'd9, 16'h1000, 16'h0010);
    wait_state(3'd4, 20);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    req0_valid = 1'b0; drop0 = 0;
    check("midrst_state", ctrl_state, 3'd0);
    check("midrst_pwr", alu_pwr_en, 1'b0);
    check("midrst_iso", iso_en, 1'b1);
    check("midrst_opcode", alu_opcode, 4'd0);
    check("midrst_alu_b", alu_b, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) tick();
    check("midrst_no_resp", rq.size(), 0);
    check("midrst_stays_off", ctrl_state, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
